sram_param: RTL and testbench
=============================

SRAM_PARAM -- requirements
Module: sram_param

Interface
REQ-001 The module SHALL have parameter ANCHO_DATO, default 8, meaning data word width in bits.
REQ-002 The module SHALL have parameter ANCHO_DIR, default 8, meaning address width in bits.
REQ-003 The module SHALL have parameter PROFUNDIDAD, default 2**ANCHO_DIR, meaning number of words implemented (at most 2**ANCHO_DIR).
REQ-004 The module SHALL have parameter MODO_RW, default 0, meaning read-during-write behaviour (0 = read-first, 1 = write-first).
REQ-005 The module SHALL have parameter VALOR_INI, default 0, meaning the value loaded into every word by the clear sweep.
REQ-006 The module SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 The module SHALL have port Rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The module SHALL have port Dir, input, ANCHO_DIR bits: word address.
REQ-009 The module SHALL have port Dato_e, input, ANCHO_DATO bits: write data.
REQ-010 The module SHALL have port We, input, 1 bit: write enable (1 = write, 0 = read).
REQ-011 The module SHALL have port En, input, 1 bit: access enable; no access when 0.
REQ-012 The module SHALL have port Dato_s, output, ANCHO_DATO bits: registered read data.
REQ-013 The module SHALL have port Valido, output, 1 bit: one-cycle pulse marking new data on Dato_s.
REQ-014 The module SHALL have port Listo, output, 1 bit: high once the clear sweep is done and accesses are accepted.
REQ-015 The module SHALL have port Err, output, 1 bit: one-cycle pulse on an out-of-range access.

Function
REQ-016 The controller SHALL have two states: LIMPIAR and ACTIVO.
REQ-017 In LIMPIAR, the controller SHALL write VALOR_INI to address k on sweep cycle k, for k = 0..PROFUNDIDAD-1, ignore En/We, and hold Listo = 0.
REQ-018 The transition LIMPIAR -> ACTIVO SHALL occur on the edge that writes address PROFUNDIDAD-1, with Listo = 1 from that edge onward.
REQ-019 In ACTIVO, a read (En=1, We=0, Dir < PROFUNDIDAD) sampled at edge N SHALL place mem[Dir] on Dato_s and set Valido = 1 after edge N (1-cycle latency).
REQ-020 In ACTIVO, a write (En=1, We=1, Dir < PROFUNDIDAD) SHALL update mem[Dir] at edge N.
REQ-021 On a write, Dato_s SHALL show the old word if MODO_RW=0 or Dato_e if MODO_RW=1, with Valido = 1.
REQ-022 When En = 0, Dato_s SHALL hold its last value and Valido SHALL be 0.
REQ-023 An access with Dir >= PROFUNDIDAD SHALL not modify memory; Dato_s SHALL become VALOR_INI and Valido = 0, Err = 1 for one cycle.
REQ-024 Back-to-back accesses on consecutive cycles SHALL each complete with no bubble.
REQ-025 A read following a write to the same address on the next cycle SHALL return the newly written data.

Reset
REQ-026 When Rst = 1 at an edge, the next state SHALL be: LIMPIAR, sweep counter 0, Dato_s = 0, Valido = 0, Listo = 0, Err = 0.
REQ-027 Rst asserted mid-sweep or mid-operation SHALL restart the full sweep from address 0; any access in that cycle SHALL be discarded.
REQ-028 Memory contents SHALL be defined only by the sweep, not by Rst directly.

Structure
REQ-029 Shared package sram_pkg SHALL hold the state enum (LIMPIAR, ACTIVO) and the MODO_RW constants (MODO_LEER_PRIMERO = 0, MODO_ESCRIBIR_PRIMERO = 1).
REQ-030 Sub-module sram_limpieza (sweep counter plus done flag) SHALL provide the clear address and Listo; the array and port logic SHALL stay in sram_param.

Verification
REQ-031 Reset then idle -> Listo rises exactly PROFUNDIDAD cycles after Rst drops; reads of addresses 0..11 return 0 with Valido pulsing.
REQ-032 Write 200..211 to addresses 0..11, then read them back -> Dato_s = 200..211, one cycle after each address.
REQ-033 MODO_RW=0: mem[5]=205, write 99 to address 5 -> Dato_s = 205; MODO_RW=1 -> Dato_s = 99; a following read returns 99.
REQ-034 PROFUNDIDAD=12: write 77 to address 12 -> Err pulse, Valido = 0; all reads of 0..11 are unchanged.
REQ-035 Rst asserted at sweep address 6 after writing 55 to address 3 -> Listo = 0 for a full PROFUNDIDAD cycles; read of address 3 then returns VALOR_INI.
REQ-036 Access attempted while Listo = 0 (write 123 to address 1) -> ignored; address 1 reads VALOR_INI after Listo rises.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the parameterised SRAM and its clear-sweep controller.
package sram_pkg;

   typedef enum logic {
      LIMPIAR,
      ACTIVO
   } estado_e;

   localparam int unsigned MODO_LEER_PRIMERO     = 0;
   localparam int unsigned MODO_ESCRIBIR_PRIMERO = 1;

   // Index width for an array of n words; never below one bit.
   function automatic int unsigned ancho_indice(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sram_limpieza.sv
// Clear-sweep controller: walks every word address once after reset, then reports ready.
module sram_limpieza
   import sram_pkg::*;
#(
   parameter int unsigned PROFUNDIDAD = 256,
   parameter int unsigned AW          = 8
) (
   input  logic          clk,
   input  logic          rst,
   output logic [AW-1:0] dir_limpieza,
   output logic          limpiando,
   output logic          listo
);

   estado_e       estado_q, estado_d;
   logic [AW-1:0] cnt_q, cnt_d;

   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      if (estado_q == LIMPIAR) begin
         if (cnt_q == AW'(PROFUNDIDAD - 1)) begin
            estado_d = ACTIVO;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q <= LIMPIAR;
         cnt_q    <= '0;
      end else begin
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
      end
   end

   assign dir_limpieza = cnt_q;
   assign limpiando    = (estado_q == LIMPIAR);
   assign listo        = (estado_q == ACTIVO);

endmodule

// File: rtl/sram_param.sv
// Single-port synchronous SRAM with a post-reset clear sweep, registered read port,
// selectable read-during-write behaviour and out-of-range error pulse.
module sram_param
   import sram_pkg::*;
#(
   parameter int unsigned               ANCHO_DATO  = 8,
   parameter int unsigned               ANCHO_DIR   = 8,
   parameter int unsigned               PROFUNDIDAD = 2 ** ANCHO_DIR,
   parameter int unsigned               MODO_RW     = 0,
   parameter logic [ANCHO_DATO-1:0]     VALOR_INI   = '0
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [ANCHO_DIR-1:0]  Dir,
   input  logic [ANCHO_DATO-1:0] Dato_e,
   input  logic                  We,
   input  logic                  En,
   output logic [ANCHO_DATO-1:0] Dato_s,
   output logic                  Valido,
   output logic                  Listo,
   output logic                  Err
);

   localparam int unsigned AW = ancho_indice(PROFUNDIDAD);

   logic [ANCHO_DATO-1:0] mem [PROFUNDIDAD];

   logic [AW-1:0]         dir_limpieza;
   logic                  limpiando;
   logic                  listo;
   logic [AW-1:0]         dir_idx;
   logic                  en_rango;
   logic [ANCHO_DATO-1:0] palabra;

   logic                  mem_we;
   logic [AW-1:0]         mem_idx;
   logic [ANCHO_DATO-1:0] mem_wdata;

   logic [ANCHO_DATO-1:0] dato_q;
   logic                  valido_q;
   logic                  err_q;

   sram_limpieza #(
      .PROFUNDIDAD (PROFUNDIDAD),
      .AW          (AW)
   ) u_limpieza (
      .clk          (Clk),
      .rst          (Rst),
      .dir_limpieza (dir_limpieza),
      .limpiando    (limpiando),
      .listo        (listo)
   );

   assign dir_idx  = Dir[AW-1:0];
   assign en_rango = (32'(Dir) < PROFUNDIDAD);
   assign palabra  = mem[dir_idx];

   // Sweep owns the array until done; a cycle with Rst high never writes.
   always_comb begin
      mem_we    = 1'b0;
      mem_idx   = dir_idx;
      mem_wdata = Dato_e;
      if (!Rst) begin
         if (limpiando) begin
            mem_we    = 1'b1;
            mem_idx   = dir_limpieza;
            mem_wdata = VALOR_INI;
         end else if (En && We && en_rango) begin
            mem_we = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (mem_we) begin
         mem[mem_idx] <= mem_wdata;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         dato_q   <= '0;
         valido_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         valido_q <= 1'b0;
         err_q    <= 1'b0;
         if (listo && En) begin
            if (en_rango) begin
               valido_q <= 1'b1;
               if (We && (MODO_RW == MODO_ESCRIBIR_PRIMERO)) begin
                  dato_q <= Dato_e;
               end else begin
                  dato_q <= palabra;
               end
            end else begin
               dato_q <= VALOR_INI;
               err_q  <= 1'b1;
            end
         end
      end
   end

   assign Dato_s = dato_q;
   assign Valido = valido_q;
   assign Listo  = listo;
   assign Err    = err_q;

endmodule

// File: tb/tb_sram_param.sv
// Bench for sram_param: a read-first and a write-first instance driven in lockstep and
// checked every cycle against a word-level memory model, plus literal scenario checks.
module tb_sram_param;

   localparam int unsigned   PROF = 12;
   localparam int unsigned   AD   = 4;
   localparam logic [7:0]    INI0 = 8'h00;
   localparam logic [7:0]    INI1 = 8'hA5;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       We;
   logic       En;
   logic [3:0] Dir;
   logic [7:0] Dato_e;

   logic [7:0] dato_s [2];
   logic       valido [2];
   logic       listo  [2];
   logic       err    [2];

   int n_total = 0;
   int n_pass  = 0;

   always #5 Clk = ~Clk;

   sram_param #(
      .ANCHO_DATO  (8),
      .ANCHO_DIR   (AD),
      .PROFUNDIDAD (PROF),
      .MODO_RW     (0),
      .VALOR_INI   (INI0)
   ) dut0 (
      .Clk    (Clk),
      .Rst    (Rst),
      .Dir    (Dir),
      .Dato_e (Dato_e),
      .We     (We),
      .En     (En),
      .Dato_s (dato_s[0]),
      .Valido (valido[0]),
      .Listo  (listo[0]),
      .Err    (err[0])
   );

   sram_param #(
      .ANCHO_DATO  (8),
      .ANCHO_DIR   (AD),
      .PROFUNDIDAD (PROF),
      .MODO_RW     (1),
      .VALOR_INI   (INI1)
   ) dut1 (
      .Clk    (Clk),
      .Rst    (Rst),
      .Dir    (Dir),
      .Dato_e (Dato_e),
      .We     (We),
      .En     (En),
      .Dato_s (dato_s[1]),
      .Valido (valido[1]),
      .Listo  (listo[1]),
      .Err    (err[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: words, cycles since reset, and the last output of each instance.
   logic [7:0] m_mem [2][PROF];
   logic [7:0] m_dato [2];
   logic       m_val;
   logic       m_err;
   int         m_cyc     = 0;
   bit         m_started = 1'b0;

   function automatic logic [7:0] ini_of(input int k);
      return (k == 0) ? INI0 : INI1;
   endfunction

   always @(posedge Clk) begin
      if (Rst) begin
         m_started = 1'b1;
         m_cyc     = 0;
         m_dato[0] = 8'h00;
         m_dato[1] = 8'h00;
         m_val     = 1'b0;
         m_err     = 1'b0;
      end else if (m_started) begin
         m_val = 1'b0;
         m_err = 1'b0;
         if (m_cyc < PROF) begin
            for (int k = 0; k < 2; k++) m_mem[k][m_cyc] = ini_of(k);
            m_cyc++;
         end else if (En) begin
            if (int'(Dir) < PROF) begin
               m_val = 1'b1;
               for (int k = 0; k < 2; k++) begin
                  // instance 1 is write-first, instance 0 read-first
                  m_dato[k] = (We && k == 1) ? Dato_e : m_mem[k][Dir];
                  if (We) m_mem[k][Dir] = Dato_e;
               end
            end else begin
               m_err = 1'b1;
               for (int k = 0; k < 2; k++) m_dato[k] = ini_of(k);
            end
         end
      end
   end

   always @(negedge Clk) begin
      if (m_started) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("dato_s[%0d]", k), 32'(dato_s[k]), 32'(m_dato[k]));
            check($sformatf("valido[%0d]", k), 32'(valido[k]), 32'(m_val));
            check($sformatf("listo[%0d]", k), 32'(listo[k]), 32'(m_cyc >= PROF));
            check($sformatf("err[%0d]", k), 32'(err[k]), 32'(m_err));
         end
      end
   end

   task automatic acc(input logic e, input logic w, input logic [3:0] d, input logic [7:0] x);
      En     = e;
      We     = w;
      Dir    = d;
      Dato_e = x;
      @(negedge Clk);
      En = 1'b0;
      We = 1'b0;
   endtask

   // Counts cycles until Listo, optionally hammering a write to address 1 meanwhile.
   task automatic wait_listo(input string name, input logic try_write);
      int n = 0;
      do begin
         En     = try_write;
         We     = 1'b1;
         Dir    = 4'd1;
         Dato_e = 8'd123;
         @(negedge Clk);
         n++;
      end while (listo[0] !== 1'b1 && n < 100);
      En = 1'b0;
      We = 1'b0;
      check(name, 32'(n), 32'd12);
   endtask

   initial begin
      Rst    = 1'b1;
      En     = 1'b0;
      We     = 1'b0;
      Dir    = '0;
      Dato_e = '0;
      @(negedge Clk);
      @(negedge Clk);
      check("reset_dato", 32'(dato_s[0]), 32'd0);
      check("reset_listo", 32'(listo[1]), 32'd0);
      Rst = 1'b0;
      wait_listo("listo_after_reset", 1'b0);

      for (int i = 0; i < 12; i++) begin
         acc(1'b1, 1'b0, 4'(i), 8'd0);
         check("read_clear0", 32'(dato_s[0]), 32'd0);
         check("read_clear1", 32'(dato_s[1]), 32'hA5);
         check("read_clear_valid", 32'(valido[0]), 32'd1);
      end

      for (int i = 0; i < 12; i++) acc(1'b1, 1'b1, 4'(i), 8'(200 + i));
      for (int i = 0; i < 12; i++) begin
         acc(1'b1, 1'b0, 4'(i), 8'd0);
         check("readback", 32'(dato_s[0]), 32'(200 + i));
      end

      acc(1'b1, 1'b1, 4'd5, 8'd99);
      check("rdw_read_first", 32'(dato_s[0]), 32'd205);
      check("rdw_write_first", 32'(dato_s[1]), 32'd99);
      acc(1'b1, 1'b0, 4'd5, 8'd0);
      check("read_after_write", 32'(dato_s[0]), 32'd99);

      acc(1'b1, 1'b1, 4'd12, 8'd77);
      check("oob_err", 32'(err[0]), 32'd1);
      check("oob_valido", 32'(valido[1]), 32'd0);
      check("oob_dato", 32'(dato_s[1]), 32'hA5);
      for (int i = 0; i < 12; i++) acc(1'b1, 1'b0, 4'(i), 8'd0);

      acc(1'b1, 1'b1, 4'd3, 8'd55);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      repeat (6) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      wait_listo("listo_after_midsweep_reset", 1'b1);
      acc(1'b1, 1'b0, 4'd3, 8'd0);
      check("cleared_addr3", 32'(dato_s[1]), 32'hA5);
      acc(1'b1, 1'b0, 4'd1, 8'd0);
      check("ignored_write_addr1", 32'(dato_s[0]), 32'd0);

      for (int i = 0; i < 800; i++) begin
         Rst    = ($urandom_range(0, 99) == 0);
         En     = ($urandom_range(0, 3) != 0);
         We     = $urandom_range(0, 1) != 0;
         Dir    = 4'($urandom_range(0, 15));
         Dato_e = 8'($urandom_range(0, 255));
         @(negedge Clk);
      end
      Rst = 1'b0;
      En  = 1'b0;
      @(negedge Clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
